id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised, registered instruction-decode stage for the 64-bit-instruction core. Decodes
//  mem type inst[63:60] and opcode inst[59:52], reads the regfile, forwards from EX/MEM,
//  detects load-use hazards and presents a registered ID/EX bundle under valid/ready handshakes.
//  Sits between the IF/ID register and the EX stage; replaces the combinational decoder.
// PARAMETERS
//  DATA_W       32  operand / register width; imm field inst[41:10] is 32 bits, zero/sign-extended or truncated
//  REG_AW       5   register address width (field positions fixed for 5)
//  SIGN_EXT_IMM 0   1: sign-extend imm to DATA_W, 0: zero-extend
//  FWD_EN       1   0: no forwarding, any RAW match on EX/MEM stalls instead
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, synchronous, active-high
//  flush          in   1       kill held and incoming instruction (branch/exception)
//  in_valid       in   1       IF/ID bundle valid
//  in_ready       out  1       ID can accept this cycle
//  pc_i           in   32      instruction address
//  inst_i         in   64      instruction word
//  reg1_read_o    out  1       regfile port 1 enable (comb)
//  reg2_read_o    out  1       regfile port 2 enable (comb)
//  reg1_addr_o    out  REG_AW  inst[46:42] (comb)
//  reg2_addr_o    out  REG_AW  inst[41:37] (comb)
//  reg1_data_i    in   DATA_W  regfile read data 1 (same cycle)
//  reg2_data_i    in   DATA_W  regfile read data 2 (same cycle)
//  ex_wreg_i/ex_wd_i/ex_wdata_i/ex_is_load_i  in 1/REG_AW/DATA_W/1  EX-stage result
//  mem_wreg_i/mem_wd_i/mem_wdata_i            in 1/REG_AW/DATA_W    MEM-stage result
//  out_valid      out  1       registered bundle valid
//  out_ready      in   1       EX accepts bundle
//  aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o  out  AluOpBus/AluSelBus/DATA_W/DATA_W/REG_AW/1/32
//  illegal_o      out  1       registered: bundle is an undecoded instruction
// BEHAVIOUR
//  Decode (comb): MEM_SREG = reg-imm: read rs1 only, reg2 operand = imm; MEM_RREG = reg-reg:
//   read rs1, rs2. Ops EXE_OR/AND/XOR -> EXE_RES_LOGIC, EXE_ADD/SUB -> EXE_RES_ARITH, wreg=1,
//   wd=inst[51:47]. Any other mem/op: NOP op, wreg=0, reads off, illegal=1.
//  Operand priority per source: not read -> imm (port2) / 0 (port1); addr==0 -> 0;
//   EX match (ex_wreg & ex_wd==addr & !ex_is_load) -> ex_wdata; else MEM match -> mem_wdata;
//   else regfile data. EX beats MEM on simultaneous match.
//  Stall: hazard = in_valid & read source matches EX with ex_is_load (addr!=0), or any EX/MEM
//   match when FWD_EN=0. hazard -> in_ready=0, no capture; output register loads a bubble
//   (out_valid=0) if it is empty/being consumed.
//  Handshake: output reg advances when !out_valid | out_ready. in_ready = advance & !hazard.
//   Capture on in_valid & in_ready: all bundle outputs registered, latency 1 cycle.
//   out_valid & !out_ready: every bundle output held stable, in_ready=0.
//  flush: next edge out_valid=0, illegal_o=0, wreg_o=0; in_ready=0 that cycle (input dropped).
//  Reset (and flush): out_valid=0, aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, wd=0, wreg=0,
//   reg1_o=reg2_o=0, pc_o=0, illegal=0. Comb reg*_read_o=0, addrs=0 while rst; reset mid-stall
//   clears bundle, no replay.
//  Width: imm truncated to DATA_W if DATA_W<32; extended per SIGN_EXT_IMM if DATA_W>32.
// TESTING
//  1 rst high 2 cycles, in_valid=1 -> out_valid=0, wreg_o=0, aluop=EXE_NOP_OP, read enables 0.
//  2 MEM_SREG/EXE_OR rs1=3 (r3=0x0F00), imm=0x00F0, wd=5 -> next cycle out_valid, reg1=0x0F00,
//    reg2=0x00F0, aluop=EXE_OR_OP, wd=5, wreg=1.
//  3 MEM_RREG ADD rs1=4,rs2=4; EX writes r4=0x11, MEM writes r4=0x22 -> reg1=reg2=0x11.
//  4 rs1=7 with ex_is_load, ex_wd=7 -> in_ready=0 one cycle, bubble out_valid=0, then issue
//    with mem_wdata forwarded.
//  5 out_ready=0 for 3 cycles with valid bundle -> outputs constant, in_ready=0; flush -> out_valid=0.
//  6 mem=0xF op=0xFF -> illegal_o=1, wreg_o=0; SIGN_EXT_IMM=1,DATA_W=32 imm 0x80000000 passes unchanged.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Handshake bundles around the decode stage: fetch-side request and the registered ID/EX bundle.
interface id_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_i;
  logic [63:0] inst_i;
  modport master (output in_valid, pc_i, inst_i, input in_ready);
  modport slave  (input in_valid, pc_i, inst_i, output in_ready);
endinterface

interface id_bundle_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic [31:0]       pc_o;
  logic              illegal_o;
  modport master (output out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o,
                         illegal_o, input out_ready);
  modport slave  (input out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o,
                        illegal_o, output out_ready);
endinterface

// File: rtl/id_stage_pipe.sv
// Registered instruction decode: field decode, regfile read, EX/MEM forwarding, load-use stall.
module id_operand_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              rd_en,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] dflt,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);
  logic ex_hit, mem_hit, live;
  assign ex_hit  = ex_wreg && (ex_wd == addr);
  assign mem_hit = mem_wreg && (mem_wd == addr);
  assign live    = rd_en && (addr != '0);

  // a load in EX has no data yet; without forwarding every in-flight writer stalls
  assign hazard = live && ((ex_hit && ex_is_load) || (!FWD_EN && (ex_hit || mem_hit)));

  always_comb begin
    data = rf_data;
    if (!rd_en)                             data = dflt;
    else if (addr == '0)                    data = '0;
    else if (FWD_EN && ex_hit && !ex_is_load) data = ex_wdata;
    else if (FWD_EN && mem_hit)             data = mem_wdata;
  end
endmodule

module id_stage_pipe #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter bit SIGN_EXT_IMM = 1'b0,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  id_fetch_if.slave         up,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  id_bundle_if.master       dn
);
  localparam logic [3:0] MEM_SREG = 4'h1;
  localparam logic [3:0] MEM_RREG = 4'h2;
  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_AND_OP = 8'h24;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_ADD_OP = 8'h20;
  localparam logic [7:0] EXE_SUB_OP = 8'h22;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  logic [3:0]        mem;
  logic [7:0]        op;
  logic [31:0]       imm32;
  logic [DATA_W-1:0] imm;
  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic              wreg, illegal, rd1, rd2;
  logic [REG_AW-1:0] wd;

  assign mem   = up.inst_i[63:60];
  assign op    = up.inst_i[59:52];
  assign imm32 = up.inst_i[41:10];

  generate
    if (DATA_W <= 32) begin : g_imm_trunc
      assign imm = imm32[DATA_W-1:0];
    end else if (SIGN_EXT_IMM) begin : g_imm_sext
      assign imm = {{(DATA_W-32){imm32[31]}}, imm32};
    end else begin : g_imm_zext
      assign imm = {{(DATA_W-32){1'b0}}, imm32};
    end
  endgenerate

  always_comb begin
    aluop   = EXE_NOP_OP;
    alusel  = EXE_RES_NOP;
    wreg    = 1'b0;
    wd      = '0;
    illegal = 1'b1;
    rd1     = 1'b0;
    rd2     = 1'b0;
    if (mem == MEM_SREG || mem == MEM_RREG) begin
      case (op)
        EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP: begin alusel = EXE_RES_LOGIC; illegal = 1'b0; end
        EXE_ADD_OP, EXE_SUB_OP:            begin alusel = EXE_RES_ARITH; illegal = 1'b0; end
        default: ;
      endcase
      if (!illegal) begin
        aluop = op;
        wreg  = 1'b1;
        wd    = up.inst_i[51:47];
        rd1   = 1'b1;
        rd2   = (mem == MEM_RREG);
      end
    end
  end

  assign reg1_read_o = rd1 && !rst;
  assign reg2_read_o = rd2 && !rst;
  assign reg1_addr_o = rst ? '0 : up.inst_i[46:42];
  assign reg2_addr_o = rst ? '0 : up.inst_i[41:37];

  // operand lane 0 defaults to zero, lane 1 to the immediate
  logic [1:0]                    rd_en, haz;
  logic [1:0][REG_AW-1:0]        addr;
  logic [1:0][DATA_W-1:0]        rf_data, dflt, opnd;

  assign rd_en   = {reg2_read_o, reg1_read_o};
  assign addr    = {reg2_addr_o, reg1_addr_o};
  assign rf_data = {reg2_data_i, reg1_data_i};
  assign dflt    = {imm, {DATA_W{1'b0}}};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_opnd
      id_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel (
        .rd_en(rd_en[i]), .addr(addr[i]), .rf_data(rf_data[i]), .dflt(dflt[i]),
        .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
        .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .data(opnd[i]), .hazard(haz[i]));
    end
  endgenerate

  logic hazard, advance, take;
  assign hazard      = up.in_valid && (|haz);
  assign advance     = !dn.out_valid || dn.out_ready;
  assign up.in_ready = advance && !hazard && !flush && !rst;
  assign take        = up.in_valid && up.in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dn.out_valid <= 1'b0;
      dn.aluop_o   <= EXE_NOP_OP;
      dn.alusel_o  <= EXE_RES_NOP;
      dn.reg1_o    <= '0;
      dn.reg2_o    <= '0;
      dn.wd_o      <= '0;
      dn.wreg_o    <= 1'b0;
      dn.pc_o      <= '0;
      dn.illegal_o <= 1'b0;
    end else if (advance) begin
      dn.out_valid <= take;
      if (take) begin
        dn.aluop_o   <= aluop;
        dn.alusel_o  <= alusel;
        dn.reg1_o    <= opnd[0];
        dn.reg2_o    <= opnd[1];
        dn.wd_o      <= wd;
        dn.wreg_o    <= wreg;
        dn.pc_o      <= up.pc_i;
        dn.illegal_o <= illegal;
      end else begin
        dn.wreg_o    <= 1'b0;
        dn.illegal_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, load-use stall, backpressure, flush, reset.
module tb_id_stage_pipe;
  localparam logic [3:0] M_SREG = 4'h1, M_RREG = 4'h2;
  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26,
                         OP_ADD = 8'h20;
  localparam logic [2:0] S_LOGIC = 3'b001, S_ARITH = 3'b100;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic        ex_wreg = 0, ex_is_load = 0, mem_wreg = 0;
  logic [4:0]  ex_wd = 0, mem_wd = 0;
  logic [31:0] ex_wdata = 0, mem_wdata = 0;
  logic [31:0] rf [32];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_fetch_if fi ();
  id_bundle_if #(.DATA_W(32), .REG_AW(5)) bo ();

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .SIGN_EXT_IMM(1'b1), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .up(fi),
    .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .dn(bo));

  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] m, input logic [7:0] op,
                                     input logic [4:0] wd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm);
    logic [63:0] r;
    r = '0;
    r[63:60] = m; r[59:52] = op; r[51:47] = wd; r[46:42] = rs1; r[41:10] = imm;
    if (rs2 != 5'd0) r[41:37] = rs2;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [63:0] inst);
    fi.pc_i = pc; fi.inst_i = inst; fi.in_valid = 1'b1; #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[3] = 32'h0F00; rf[4] = 32'h44; rf[7] = 32'h77;
    bo.out_ready = 1'b1;
    drive(32'h100, mk(M_SREG, OP_OR, 5'd5, 5'd3, 5'd0, 32'h00F0));
    step(); step();
    chk("rst_valid", bo.out_valid, 0);
    chk("rst_wreg", bo.wreg_o, 0);
    chk("rst_aluop", bo.aluop_o, OP_NOP);
    chk("rst_rd1", reg1_read, 0);
    chk("rst_rd2", reg2_read, 0);

    // reg-imm OR
    rst = 1'b0; #1;
    chk("sreg_rd1", reg1_read, 1);
    chk("sreg_rd2", reg2_read, 0);
    chk("sreg_addr1", reg1_addr, 3);
    chk("sreg_rdy", fi.in_ready, 1);
    step();
    chk("or_valid", bo.out_valid, 1);
    chk("or_reg1", bo.reg1_o, 32'h0F00);
    chk("or_reg2", bo.reg2_o, 32'h00F0);
    chk("or_aluop", bo.aluop_o, OP_OR);
    chk("or_alusel", bo.alusel_o, S_LOGIC);
    chk("or_wd", bo.wd_o, 5);
    chk("or_wreg", bo.wreg_o, 1);
    chk("or_pc", bo.pc_o, 32'h100);

    // reg-reg ADD, EX beats MEM
    ex_wreg = 1; ex_wd = 4; ex_wdata = 32'h11;
    mem_wreg = 1; mem_wd = 4; mem_wdata = 32'h22;
    drive(32'h108, mk(M_RREG, OP_ADD, 5'd6, 5'd4, 5'd4, 32'h0));
    chk("rreg_rd2", reg2_read, 1);
    step();
    chk("add_reg1", bo.reg1_o, 32'h11);
    chk("add_reg2", bo.reg2_o, 32'h11);
    chk("add_alusel", bo.alusel_o, S_ARITH);
    chk("add_wd", bo.wd_o, 6);

    // load-use stall then MEM forward
    ex_wd = 7; ex_is_load = 1; ex_wdata = 32'hBAD; mem_wreg = 0;
    drive(32'h110, mk(M_SREG, OP_ADD, 5'd8, 5'd7, 5'd0, 32'h1));
    chk("lu_rdy", fi.in_ready, 0);
    step();
    chk("lu_bubble", bo.out_valid, 0);
    ex_wreg = 0; ex_is_load = 0; mem_wreg = 1; mem_wd = 7; mem_wdata = 32'h99; #1;
    chk("lu_rdy2", fi.in_ready, 1);
    step();
    chk("lu_valid", bo.out_valid, 1);
    chk("lu_reg1", bo.reg1_o, 32'h99);
    chk("lu_reg2", bo.reg2_o, 32'h1);
    chk("lu_pc", bo.pc_o, 32'h110);

    // backpressure holds bundle, then flush
    bo.out_ready = 1'b0;
    drive(32'h118, mk(M_SREG, OP_XOR, 5'd9, 5'd0, 5'd0, 32'h1234));
    chk("bp_rdy", fi.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", bo.out_valid, 1);
      chk("bp_reg1", bo.reg1_o, 32'h99);
      chk("bp_wd", bo.wd_o, 8);
      chk("bp_pc", bo.pc_o, 32'h110);
      chk("bp_rdy_hold", fi.in_ready, 0);
    end
    flush = 1'b1; bo.out_ready = 1'b1; #1;
    chk("fl_rdy", fi.in_ready, 0);
    step();
    flush = 1'b0;
    chk("fl_valid", bo.out_valid, 0);
    chk("fl_wreg", bo.wreg_o, 0);
    chk("fl_illegal", bo.illegal_o, 0);

    // illegal instruction
    mem_wreg = 0;
    drive(32'h120, mk(4'hF, 8'hFF, 5'd3, 5'd3, 5'd0, 32'h0));
    chk("ill_rd1", reg1_read, 0);
    step();
    chk("ill_valid", bo.out_valid, 1);
    chk("ill_flag", bo.illegal_o, 1);
    chk("ill_wreg", bo.wreg_o, 0);
    chk("ill_aluop", bo.aluop_o, OP_NOP);

    // imm MSB, and r0 never forwarded
    ex_wreg = 1; ex_wd = 0; ex_wdata = 32'hDEAD;
    drive(32'h128, mk(M_SREG, OP_AND, 5'd1, 5'd0, 5'd0, 32'h80000000));
    step();
    chk("imm_reg2", bo.reg2_o, 32'h80000000);
    chk("r0_reg1", bo.reg1_o, 0);
    chk("and_aluop", bo.aluop_o, OP_AND);
    chk("and_illegal", bo.illegal_o, 0);

    // reset during a load-use stall clears the bundle
    ex_wd = 3; ex_is_load = 1;
    drive(32'h130, mk(M_SREG, OP_OR, 5'd2, 5'd3, 5'd0, 32'h5));
    chk("rs_stall_rdy", fi.in_ready, 0);
    rst = 1'b1;
    step();
    chk("rs_valid", bo.out_valid, 0);
    chk("rs_reg2", bo.reg2_o, 0);
    chk("rs_pc", bo.pc_o, 0);
    chk("rs_addr1", reg1_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
